// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-access stage: FSM states,
// RV32 load/store width codes and byte-lane patterns.
package mem_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   localparam int SIZE_DEF = 32;
   localparam int BE_W     = SIZE_DEF / 8;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [BE_W-1:0] BE_BYTE = 4'b0001;
   localparam logic [BE_W-1:0] BE_HALF = 4'b0011;
   localparam logic [BE_W-1:0] BE_WORD = 4'b1111;

   // Only the width bits matter: signed/unsigned variants share alignment rules.
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
      return ((f3[1:0] == 2'b01) && off[0]) ||
             ((f3[1:0] == 2'b10) && (off != 2'b00));
   endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load alignment: picks the addressed byte/halfword out of the read word
// and sign- or zero-extends it to the datapath width.
module load_align
   import mem_pkg::*;
#(
   parameter int Size = 32
) (
   input  logic [Size-1:0] rdata,
   input  logic [1:0]      offset,
   input  logic [2:0]      func3,
   output logic [Size-1:0] value
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[{offset, 3'b000} +: 8];
      half_sel = rdata[{offset[1], 4'b0000} +: 16];
      case (func3)
         F3_B:    value = {{(Size-8){byte_sel[7]}}, byte_sel};
         F3_H:    value = {{(Size-16){half_sel[15]}}, half_sel};
         F3_BU:   value = {{(Size-8){1'b0}}, byte_sel};
         F3_HU:   value = {{(Size-16){1'b0}}, half_sel};
         default: value = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues one data-memory request at a time over a
// ready/valid port, stalls upstream while it is outstanding, owns MEM/WB.
module mem_stage
   import mem_pkg::*;
#(
   parameter int Size = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [2:0]        func3,
   input  logic [Size-1:0]   alu_result,
   input  logic [Size-1:0]   store_data,
   input  logic [4:0]        rd_in,
   input  logic              reg_write_in,
   output logic              stall,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [Size-1:0]   dmem_addr,
   output logic [Size/8-1:0] dmem_be,
   output logic [Size-1:0]   dmem_wdata,
   input  logic              dmem_ready,
   input  logic [Size-1:0]   dmem_rdata,
   output logic              wb_valid,
   output logic              wb_reg_write,
   output logic [4:0]        wb_rd,
   output logic [Size-1:0]   wb_data,
   output logic              misaligned_exc
);

   state_t            state;
   logic              mem_op;
   logic              misaligned;
   logic [Size/8-1:0] be_next;
   logic [Size-1:0]   wdata_next;
   logic [Size-1:0]   load_value;

   // Attributes of the outstanding access, held for the completion edge.
   logic [Size-1:0]   addr_p0;
   logic [2:0]        f3_p0;
   logic [4:0]        rd_p0;
   logic              rw_p0;
   logic              load_p0;

   assign mem_op     = in_valid & (mem_read | mem_write);
   assign misaligned = is_misaligned(func3, alu_result[1:0]);

   always_comb begin
      if (state == ACCESS) stall = ~dmem_ready;
      else                 stall = mem_op & ~misaligned;
   end

   // Loads always read the full word; stores replicate data across lanes.
   always_comb begin
      be_next    = BE_WORD;
      wdata_next = store_data;
      if (mem_write) begin
         case (func3[1:0])
            2'b00: begin
               be_next    = BE_BYTE << alu_result[1:0];
               wdata_next = {4{store_data[7:0]}};
            end
            2'b01: begin
               be_next    = BE_HALF << {alu_result[1], 1'b0};
               wdata_next = {2{store_data[15:0]}};
            end
            default: begin
               be_next    = BE_WORD;
               wdata_next = store_data;
            end
         endcase
      end
   end

   load_align #(.Size(Size)) u_load_align (
      .rdata  (dmem_rdata),
      .offset (addr_p0[1:0]),
      .func3  (f3_p0),
      .value  (load_value)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         dmem_req       <= 1'b0;
         dmem_we        <= 1'b0;
         dmem_addr      <= '0;
         dmem_be        <= '0;
         dmem_wdata     <= '0;
         addr_p0        <= '0;
         f3_p0          <= '0;
         rd_p0          <= '0;
         rw_p0          <= 1'b0;
         load_p0        <= 1'b0;
         wb_valid       <= 1'b0;
         wb_reg_write   <= 1'b0;
         wb_rd          <= '0;
         wb_data        <= '0;
         misaligned_exc <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (mem_op && !misaligned) begin
                  state        <= ACCESS;
                  dmem_req     <= 1'b1;
                  dmem_we      <= mem_write;
                  dmem_addr    <= {alu_result[Size-1:2], 2'b00};
                  dmem_be      <= be_next;
                  dmem_wdata   <= wdata_next;
                  addr_p0      <= alu_result;
                  f3_p0        <= func3;
                  rd_p0        <= rd_in;
                  rw_p0        <= reg_write_in;
                  load_p0      <= mem_read;
                  wb_valid     <= 1'b0;
                  wb_reg_write <= 1'b0;
                  misaligned_exc <= 1'b0;
               end else if (mem_op) begin
                  // Trapped access retires as a non-writing WB slot.
                  wb_valid       <= 1'b1;
                  wb_reg_write   <= 1'b0;
                  wb_rd          <= rd_in;
                  wb_data        <= alu_result;
                  misaligned_exc <= 1'b1;
               end else begin
                  wb_valid       <= in_valid;
                  wb_reg_write   <= reg_write_in;
                  wb_rd          <= rd_in;
                  wb_data        <= alu_result;
                  misaligned_exc <= 1'b0;
               end
            end
            ACCESS: begin
               misaligned_exc <= 1'b0;
               if (dmem_ready) begin
                  state        <= IDLE;
                  dmem_req     <= 1'b0;
                  wb_valid     <= 1'b1;
                  wb_rd        <= rd_p0;
                  wb_reg_write <= load_p0 & rw_p0;
                  wb_data      <= load_p0 ? load_value : addr_p0;
               end else begin
                  wb_valid     <= 1'b0;
                  wb_reg_write <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a transaction-level reference model
// compared every cycle, plus literal expectations for the key vectors.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, mem_read, mem_write, reg_write_in;
   logic [2:0]  func3;
   logic [31:0] alu_result, store_data, dmem_rdata;
   logic [4:0]  rd_in;
   logic        dmem_ready;
   logic        stall, dmem_req, dmem_we, wb_valid, wb_reg_write, misaligned_exc;
   logic [31:0] dmem_addr, dmem_wdata, wb_data;
   logic [3:0]  dmem_be;
   logic [4:0]  wb_rd;

   int checks = 0;
   int errors = 0;
   int stall_cnt = 0;
   int exc_cnt = 0;
   int s0, e0;

   always #5 clk = ~clk;

   mem_stage #(.Size(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .mem_read(mem_read),
      .mem_write(mem_write), .func3(func3), .alu_result(alu_result),
      .store_data(store_data), .rd_in(rd_in), .reg_write_in(reg_write_in),
      .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
      .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
      .misaligned_exc(misaligned_exc)
   );

   // ---------------- reference model ----------------
   function automatic logic exp_mis(input logic [2:0] f3, input logic [31:0] a);
      int w;
      w = int'(f3) % 4;
      return (w == 1 && (a % 2) != 0) || (w == 2 && (a % 4) != 0);
   endfunction

   function automatic logic [3:0] exp_be(input logic wr, input logic [2:0] f3, input logic [31:0] a);
      int w;
      w = int'(f3) % 4;
      if (!wr || w >= 2) return 4'hF;
      if (w == 0) return 4'(1 << (a % 4));
      return 4'(3 << (a % 4));
   endfunction

   function automatic logic [31:0] exp_wdata(input logic wr, input logic [2:0] f3, input logic [31:0] d);
      int w;
      w = int'(f3) % 4;
      if (wr && w == 0) return (d & 32'hFF) * 32'h0101_0101;
      if (wr && w == 1) return (d & 32'hFFFF) * 32'h0001_0001;
      return d;
   endfunction

   function automatic logic [31:0] exp_load(input logic [31:0] word, input logic [31:0] a, input logic [2:0] f3);
      logic [31:0] sh;
      int v;
      sh = word >> (8 * (a % 4));
      case (f3)
         3'b000:  begin v = $signed(sh[7:0]);  return 32'(v); end
         3'b001:  begin v = $signed(sh[15:0]); return 32'(v); end
         3'b100:  return sh & 32'hFF;
         3'b101:  return sh & 32'hFFFF;
         default: return word;
      endcase
   endfunction

   logic        m_busy, m_req, m_we, m_load, m_rw, m_wbv, m_wbrw, m_exc, m_dchk;
   logic [31:0] m_addr, m_wdata, m_a, m_wbdata;
   logic [3:0]  m_be;
   logic [2:0]  m_f3;
   logic [4:0]  m_rd, m_wbrd;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy <= 0; m_req <= 0; m_we <= 0; m_load <= 0; m_rw <= 0;
         m_wbv <= 0; m_wbrw <= 0; m_exc <= 0; m_dchk <= 0;
         m_addr <= 0; m_wdata <= 0; m_a <= 0; m_wbdata <= 0;
         m_be <= 0; m_f3 <= 0; m_rd <= 0; m_wbrd <= 0;
      end else if (!m_busy) begin
         if (in_valid && (mem_read || mem_write)) begin
            if (exp_mis(func3, alu_result)) begin
               m_wbv <= 1; m_wbrw <= 0; m_exc <= 1; m_dchk <= 0;
            end else begin
               m_busy <= 1; m_req <= 1; m_we <= mem_write;
               m_addr <= alu_result & ~32'h3;
               m_be <= exp_be(mem_write, func3, alu_result);
               m_wdata <= exp_wdata(mem_write, func3, store_data);
               m_a <= alu_result; m_f3 <= func3; m_rd <= rd_in;
               m_rw <= reg_write_in; m_load <= mem_read;
               m_wbv <= 0; m_wbrw <= 0; m_exc <= 0; m_dchk <= 0;
            end
         end else begin
            m_wbv <= in_valid; m_wbrw <= reg_write_in; m_wbrd <= rd_in;
            m_wbdata <= alu_result; m_exc <= 0; m_dchk <= 1;
         end
      end else begin
         m_exc <= 0;
         if (dmem_ready) begin
            m_busy <= 0; m_req <= 0; m_wbv <= 1; m_wbrd <= m_rd;
            m_wbrw <= m_load && m_rw;
            m_wbdata <= m_load ? exp_load(dmem_rdata, m_a, m_f3) : m_a;
            m_dchk <= 1;
         end else begin
            m_wbv <= 0; m_wbrw <= 0; m_dchk <= 0;
         end
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
      end
   endtask

   task automatic compare_cycle();
      logic exp_stall;
      if (rst) begin
         chk("rst_req", dmem_req, 0);      chk("rst_we", dmem_we, 0);
         chk("rst_addr", dmem_addr, 0);    chk("rst_be", dmem_be, 0);
         chk("rst_wdata", dmem_wdata, 0);  chk("rst_wbv", wb_valid, 0);
         chk("rst_wbrw", wb_reg_write, 0); chk("rst_wbrd", wb_rd, 0);
         chk("rst_wbdata", wb_data, 0);    chk("rst_exc", misaligned_exc, 0);
      end else begin
         exp_stall = m_busy ? !dmem_ready
                            : (in_valid && (mem_read || mem_write) && !exp_mis(func3, alu_result));
         chk("stall", stall, exp_stall);
         chk("dmem_req", dmem_req, m_req);
         chk("wb_valid", wb_valid, m_wbv);
         chk("wb_reg_write", wb_reg_write, m_wbrw);
         chk("misaligned_exc", misaligned_exc, m_exc);
         if (m_req) begin
            chk("dmem_we", dmem_we, m_we);
            chk("dmem_addr", dmem_addr, m_addr);
            chk("dmem_be", dmem_be, m_be);
            chk("dmem_wdata", dmem_wdata, m_wdata);
         end
         if (m_wbv && m_dchk) begin
            chk("wb_rd", wb_rd, m_wbrd);
            chk("wb_data", wb_data, m_wbdata);
         end
      end
      if (stall === 1'b1) stall_cnt++;
      if (misaligned_exc === 1'b1) exc_cnt++;
   endtask

   task automatic step();
      @(negedge clk);
      compare_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic go_idle();
      in_valid = 0; mem_read = 0; mem_write = 0; reg_write_in = 0;
      func3 = 0; alu_result = 0; store_data = 0; rd_in = 0;
   endtask

   task automatic drive(input logic rd_, input logic wr_, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd);
      in_valid = 1; mem_read = rd_; mem_write = wr_; func3 = f3;
      alu_result = a; store_data = sd; rd_in = rd; reg_write_in = !wr_;
   endtask

   task automatic mem_access(input logic rd_, input logic wr_, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd,
                             input int waits, input logic [31:0] rdata);
      drive(rd_, wr_, f3, a, sd, rd);
      dmem_ready = 0;
      step();
      repeat (waits) step();
      dmem_ready = 1; dmem_rdata = rdata;
      step();
      dmem_ready = 0;
      go_idle();
   endtask

   // ---------------- directed vectors ----------------
   initial begin
      go_idle();
      dmem_ready = 0; dmem_rdata = 0; rst = 0;
      #1 rst = 1;
      step(); step();
      rst = 0;
      chk("reset_req_lit", dmem_req, 0);
      chk("reset_wbv_lit", wb_valid, 0);

      // Non-memory op; dmem_ready in IDLE must be ignored.
      in_valid = 1; alu_result = 32'h0000_1234; rd_in = 5; reg_write_in = 1;
      dmem_ready = 1; dmem_rdata = 32'hDEAD_DEAD;
      #1 chk("alu_stall_lit", stall, 0);
      step();
      dmem_ready = 0; go_idle();
      chk("alu_wbv_lit", wb_valid, 1);
      chk("alu_wbrd_lit", wb_rd, 5);
      chk("alu_wbdata_lit", wb_data, 32'h0000_1234);
      chk("alu_req_lit", dmem_req, 0);
      step();

      // SB with three wait cycles.
      s0 = stall_cnt;
      drive(0, 1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 7);
      step();
      chk("sb_addr_lit", dmem_addr, 32'h0000_0100);
      chk("sb_be_lit", dmem_be, 4'b1000);
      chk("sb_wdata_lit", dmem_wdata, 32'hA5A5_A5A5);
      chk("sb_we_lit", dmem_we, 1);
      repeat (3) step();
      dmem_ready = 1;
      step();
      dmem_ready = 0; go_idle();
      chk("sb_wbrw_lit", wb_reg_write, 0);
      chk("sb_wbv_lit", wb_valid, 1);
      chk("sb_stall_cycles_lit", stall_cnt - s0, 4);
      step();

      // LB / LBU from lane 2.
      mem_access(1, 0, 3'b000, 32'h0000_0202, 0, 9, 0, 32'h0080_0000);
      chk("lb_lit", wb_data, 32'hFFFF_FF80);
      mem_access(1, 0, 3'b100, 32'h0000_0202, 0, 9, 0, 32'h0080_0000);
      chk("lbu_lit", wb_data, 32'h0000_0080);
      step();

      // Misaligned LH: one-cycle exception, no request, no stall.
      s0 = stall_cnt; e0 = exc_cnt;
      drive(1, 0, 3'b001, 32'h0000_0301, 0, 3);
      step();
      go_idle();
      chk("mis_exc_lit", misaligned_exc, 1);
      chk("mis_wbv_lit", wb_valid, 1);
      chk("mis_wbrw_lit", wb_reg_write, 0);
      chk("mis_req_lit", dmem_req, 0);
      step(); step();
      chk("mis_exc_pulse_lit", exc_cnt - e0, 1);
      chk("mis_stall_lit", stall_cnt - s0, 0);

      // LW held waiting, reset asserted mid-access.
      drive(1, 0, 3'b010, 32'h0000_0400, 0, 4);
      step(); step(); step();
      chk("lw_req_held_lit", dmem_req, 1);
      chk("lw_addr_held_lit", dmem_addr, 32'h0000_0400);
      rst = 1; go_idle();
      #1;
      chk("lw_rst_req_lit", dmem_req, 0);
      chk("lw_rst_wbv_lit", wb_valid, 0);
      step();
      rst = 0;
      step();

      // Other widths, checked by the model.
      mem_access(0, 1, 3'b001, 32'h0000_0502, 32'h0000_BEEF, 1, 1, 0);
      mem_access(0, 1, 3'b010, 32'h0000_0600, 32'hDEAD_BEEF, 2, 0, 0);
      mem_access(1, 0, 3'b001, 32'h0000_0702, 0, 12, 1, 32'h8001_7F00);
      chk("lh_lit", wb_data, 32'hFFFF_8001);
      mem_access(1, 0, 3'b010, 32'h0000_0708, 0, 13, 0, 32'h1234_5678);
      step();

      // LHU followed back-to-back by LW.
      drive(1, 0, 3'b101, 32'h0000_0402, 0, 10);
      step();
      dmem_ready = 1; dmem_rdata = 32'hBEEF_1234;
      step();
      dmem_ready = 0;
      drive(1, 0, 3'b010, 32'h0000_0404, 0, 11);
      #1;
      chk("lhu_lit", wb_data, 32'h0000_BEEF);
      chk("b2b_gap_req_lit", dmem_req, 0);
      chk("b2b_gap_stall_lit", stall, 1);
      step();
      chk("b2b_req_lit", dmem_req, 1);
      chk("b2b_addr_lit", dmem_addr, 32'h0000_0404);
      dmem_ready = 1; dmem_rdata = 32'h1122_3344;
      step();
      dmem_ready = 0; go_idle();
      chk("b2b_lw_lit", wb_data, 32'h1122_3344);
      step(); step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage.
- Consumes the ALU result (as address or pass-through data), the rs2 store data and the load/store func3.
- Drives a ready/valid data-memory port with byte lanes, aligns and sign/zero-extends loads, and stalls the pipeline while a memory access is outstanding.
- Owns the MEM/WB pipeline register feeding write-back.

Parameters:
- Size, 32, datapath width. Byte-lane logic is defined for Size=32 only; byte-enable width is Size/8.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  EX/MEM slot holds a valid instruction
- mem_read  in  1  instruction is a load
- mem_write  in  1  instruction is a store; mem_read and mem_write are never both 1
- func3  in  3  RV32 load/store width/sign code
- alu_result  in  Size  effective address, or result for non-memory ops
- store_data  in  Size  rs2 value for stores
- rd_in  in  5  destination register
- reg_write_in  in  1  instruction writes rd
- stall  out  1  combinational; hold all upstream stages this cycle
- dmem_req  out  1  memory request valid
- dmem_we  out  1  1 = write
- dmem_addr  out  Size  word-aligned address (low 2 bits forced 0)
- dmem_be  out  Size/8  byte enables
- dmem_wdata  out  Size  lane-positioned write data
- dmem_ready  in  1  memory accepts/completes the request this cycle
- dmem_rdata  in  Size  read word, valid when dmem_ready=1 for a read
- wb_valid  out  1  registered; WB slot valid
- wb_reg_write  out  1  registered
- wb_rd  out  5  registered
- wb_data  out  Size  registered; load data or alu_result
- misaligned_exc  out  1  registered one-cycle pulse

Behaviour:
- Reset, asynchronous: state=IDLE. dmem_req, dmem_we, wb_valid, wb_reg_write and misaligned_exc are 0. dmem_addr, dmem_be, dmem_wdata, wb_rd and wb_data are all-zero.
- mem_op = in_valid & (mem_read | mem_write).
- Misaligned when:
  - func3[1:0]=01 and addr[0]=1, or
  - func3[1:0]=10 and addr[1:0]≠00.
- FSM states: IDLE, ACCESS.
- IDLE:
  - No mem_op: the WB register captures in_valid, reg_write_in, rd_in and alu_result every edge. stall=0. Latency is 1 cycle.
  - Aligned mem_op: stall=1. At the edge, go to ACCESS and register dmem_req=1, dmem_we=mem_write, addr, be, wdata and the load attributes. The WB register loads wb_valid=0 (bubble).
  - Misaligned mem_op: no request, stall=0. At the edge, wb_valid=1, wb_reg_write=0, misaligned_exc=1.
- ACCESS:
  - dmem_req and all request fields are held stable until dmem_ready=1.
  - stall = ~dmem_ready.
  - On the edge with dmem_ready=1:
    - dmem_req goes to 0 and state goes to IDLE.
    - WB gets wb_valid=1 and wb_rd from the registered rd.
    - Load: wb_reg_write=registered reg_write; wb_data = aligned load value.
    - Store: wb_reg_write=0; wb_data = address.
  - The upstream instruction presented in the same ready cycle is evaluated on the next cycle in IDLE. No back-to-back issue, so the minimum memory latency is 2 cycles.
- Store lanes:
  - SB (000): be=0001<<a[1:0]; wdata = byte replicated ×4.
  - SH (001): be=0011<<{a[1],0}; wdata = halfword replicated ×2.
  - SW (010): be=1111.
- Loads: be=1111. The result is extracted from the addressed lane of dmem_rdata.
  - LB (000) / LH (001): sign-extended.
  - LBU (100) / LHU (101): zero-extended.
  - LW (010), and the unused codes 011, 110, 111: full word.
- misaligned_exc is high for exactly one cycle per offending instruction.
- dmem_ready while in IDLE is ignored.
- Reset asserted mid-ACCESS: dmem_req drops immediately (asynchronous) and the access is abandoned.

Decomposition:
- Package mem_pkg:
  - state enum {IDLE, ACCESS}
  - func3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101
  - BE_W=Size/8
- Sub-module load_align (combinational): inputs rdata, byte offset, func3; output the extended Size-bit value. Instantiated once.

Test Plan:
- Non-memory op: alu_result=0x0000_1234, rd=5, reg_write=1 → next edge wb_valid=1, wb_rd=5, wb_data=0x1234; stall=0 throughout.
- SB, addr=0x0000_0103, store_data=0x0000_00A5, ready after 3 wait cycles:
  - dmem_addr=0x100, be=1000, wdata=0xA5A5_A5A5.
  - stall=1 for 4 cycles; then wb_reg_write=0.
- LB, addr=0x202, rdata=0x0080_0000, ready first cycle → wb_data=0xFFFF_FF80. Same stimulus with LBU → 0x0000_0080.
- LH at addr=0x301 → no dmem_req, misaligned_exc pulses 1 cycle, wb_reg_write=0, stall never asserted.
- LW at addr=0x400 with ready held 0 for 5 cycles: req and addr stable throughout. Assert rst in cycle 3 → dmem_req=0 immediately, state IDLE, wb_valid=0.
- LHU at addr=0x402, rdata=0xBEEF_1234 → wb_data=0x0000_BEEF. Back-to-back load follows; the second request is issued one cycle after the first completes.
